muldiv_seq: RTL

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq_if.sv | 38 +++
 rtl/muldiv_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if
// Purpose: bundles the E-stage handshake and result signals of the sequential
//          multiply/divide unit so the pipeline and the unit connect through
//          one port.
// Signals:
//   startE  - E-stage instruction is MULT/MULTU/DIV/DIVU
//   mdopE   - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   srcaE   - rs operand (multiplicand / dividend)
//   srcbE   - rt operand (multiplier / divisor)
//   flushE  - E-stage flush, cancels an in-flight operation
//   stallE  - holds F/D/E while the operation is unfinished
//   busy    - unit is not idle
//   hilo_we - one-cycle HI/LO write strobe
//   hi_o    - product[63:32] or remainder
//   lo_o    - product[31:0] or quotient
// Modports: master drives the request side (pipeline), slave is the unit.
interface muldiv_seq_if;
  logic        startE;
  logic [1:0]  mdopE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        flushE;
  logic        stallE;
  logic        busy;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output startE, mdopE, srcaE, srcbE, flushE,
    input  stallE, busy, hilo_we, hi_o, lo_o
  );

  modport slave (
    input  startE, mdopE, srcaE, srcbE, flushE,
    output stallE, busy, hilo_we, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq
// Purpose: multi-cycle MIPS-style HI/LO unit. MULT/MULTU finish in one
//          working cycle; DIV/DIVU run a 32-step restoring divide on operand
//          magnitudes, one quotient bit per cycle, then fix up signs.
// Ports:
//   clk - clock, all state updates on the rising edge
//   rst - asynchronous active-high reset
//   bus - muldiv_seq_if.slave (request, stall, busy, HI/LO result + strobe)
module muldiv_seq (
  input  logic          clk,
  input  logic          rst,
  muldiv_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      r_state;
  logic        r_signed;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [5:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic [31:0] w_aMag;
  logic [31:0] w_bMag;
  logic [63:0] w_aExt;
  logic [63:0] w_bExt;
  logic [63:0] w_prod;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [31:0] w_remNext;
  logic [31:0] w_quoNext;
  logic        w_negQ;
  logic        w_negR;
  logic [31:0] w_quoFinal;
  logic [31:0] w_remFinal;

  // A flush in the same cycle wins over a start, so nothing is accepted.
  assign w_accept = (r_state == IDLE) & bus.startE & ~bus.flushE;

  // The dividend magnitude is taken straight from the inputs so the
  // quotient shift register can be loaded on acceptance.
  assign w_aMag = (~bus.mdopE[0] & bus.srcaE[31]) ? -bus.srcaE : bus.srcaE;
  assign w_bMag = (r_signed & r_b[31]) ? -r_b : r_b;

  // Sign- or zero-extending both operands to 64 bits lets one multiplier
  // serve MULT and MULTU; the low 64 bits of the product are exact.
  assign w_aExt = {(r_signed ? {32{r_a[31]}} : 32'd0), r_a};
  assign w_bExt = {(r_signed ? {32{r_b[31]}} : 32'd0), r_b};
  assign w_prod = w_aExt * w_bExt;

  // One restoring step: the partial remainder is always below the divisor,
  // so after shifting in the next dividend bit it needs 33 bits, and a
  // successful subtraction always fits back into 32.
  assign w_shift   = {r_rem, r_quo[31]};
  assign w_ge      = (w_shift >= {1'b0, w_bMag});
  assign w_diff    = w_shift[31:0] - w_bMag;
  assign w_remNext = w_ge ? w_diff : w_shift[31:0];
  assign w_quoNext = {r_quo[30:0], w_ge};

  // Quotient is negative when the signs differ; remainder follows the
  // dividend. 0x80000000 / -1 wraps back to 0x80000000 naturally.
  assign w_negQ     = r_signed & (r_a[31] ^ r_b[31]);
  assign w_negR     = r_signed & r_a[31];
  assign w_quoFinal = w_negQ ? -w_quoNext : w_quoNext;
  assign w_remFinal = w_negR ? -w_remNext : w_remNext;

  // Single state machine: accepts the operation, works through MUL or the
  // divide iterations, commits HI/LO only on the transition into DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_signed <= 1'b0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_quo    <= 32'd0;
      r_rem    <= 32'd0;
      r_cnt    <= 6'd0;
      r_we     <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_signed <= ~bus.mdopE[0];
            r_a      <= bus.srcaE;
            r_b      <= bus.srcbE;
            r_quo    <= w_aMag;
            r_rem    <= 32'd0;
            r_cnt    <= 6'd0;
            r_state  <= bus.mdopE[1] ? DIV : MUL;
          end
        end
        MUL: begin
          if (bus.flushE) begin
            r_state <= IDLE;
          end else begin
            r_hi    <= w_prod[63:32];
            r_lo    <= w_prod[31:0];
            r_we    <= 1'b1;
            r_state <= DONE;
          end
        end
        DIV: begin
          if (bus.flushE) begin
            r_state <= IDLE;
          end else if ((r_cnt == 6'd0) && (r_b == 32'd0)) begin
            r_hi    <= r_a;
            r_lo    <= 32'hFFFF_FFFF;
            r_we    <= 1'b1;
            r_state <= DONE;
          end else if (r_cnt == 6'd31) begin
            r_hi    <= w_remFinal;
            r_lo    <= w_quoFinal;
            r_we    <= 1'b1;
            r_cnt   <= 6'd0;
            r_state <= DONE;
          end else begin
            r_quo <= w_quoNext;
            r_rem <= w_remNext;
            r_cnt <= r_cnt + 6'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // The strobe is gated by flush so a flushed DONE cycle never writes HI/LO.
  assign bus.stallE  = w_accept | (r_state == MUL) | (r_state == DIV);
  assign bus.busy    = (r_state != IDLE);
  assign bus.hilo_we = r_we & ~bus.flushE;
  assign bus.hi_o    = r_hi;
  assign bus.lo_o    = r_lo;

endmodule
